// File: rtl/fwd_hazard_scoreboard.sv
// rtl/fwd_hazard_scoreboard.sv - in-flight write scoreboard picking EX forwarding sources and load-use stalls
module fwd_hazard_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 3,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [ADDR_W-1:0]         id_rd,
    input  logic                      id_reg_w,
    input  logic                      id_is_load,
    output logic                      stall,
    output logic                      ex_valid,
    output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt
);

    // Index 0 is P1 (EX); index DEPTH-1 is the oldest tracked position.
    logic [DEPTH-1:0]  p_valid;
    logic [DEPTH-1:0]  p_wr;
    logic [DEPTH-1:0]  p_load;
    logic [ADDR_W-1:0] p_rd [DEPTH];

    logic [NUM_SRC*SEL_W-1:0] fwd_next;
    logic [NUM_SRC-1:0]       hazard;
    logic [ADDR_W-1:0]        src;

    assign ex_valid = p_valid[0];

    // Scanning oldest to youngest lets the youngest producer overwrite older hits.
    always_comb begin
        fwd_next = '0;
        hazard   = '0;
        src      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src = id_rs[i*ADDR_W +: ADDR_W];
            if (id_rs_used[i] && (src != '0)) begin
                for (int k = DEPTH - 1; k >= 1; k--) begin
                    if (p_valid[k-1] && p_wr[k-1] && (p_rd[k-1] == src)) begin
                        fwd_next[i*SEL_W +: SEL_W] = SEL_W'(k);
                        hazard[i]                  = p_load[k-1] && ((k + 1) < LOAD_READY);
                    end
                end
            end
        end
        stall = id_valid && !flush && (|hazard);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid    <= '0;
            p_wr       <= '0;
            p_load     <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                p_rd[k] <= '0;
            end
            ex_fwd_sel <= '0;
            stall_cnt  <= '0;
        end else if (!hold) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                p_valid[k] <= p_valid[k-1];
                p_wr[k]    <= p_wr[k-1];
                p_load[k]  <= p_load[k-1];
                p_rd[k]    <= p_rd[k-1];
            end
            if (flush || stall) begin
                // Bubble into EX; a flushed ID instruction is simply dropped.
                p_valid[0] <= 1'b0;
                p_wr[0]    <= 1'b0;
                p_load[0]  <= 1'b0;
                p_rd[0]    <= '0;
                ex_fwd_sel <= '0;
                if (stall && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
            end else begin
                p_valid[0] <= id_valid;
                p_wr[0]    <= id_reg_w && (id_rd != '0);
                p_load[0]  <= id_is_load;
                p_rd[0]    <= id_rd;
                ex_fwd_sel <= fwd_next;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb/tb_fwd_hazard_scoreboard.sv - vector table and scoreboard bench for fwd_hazard_scoreboard
module tb_fwd_hazard_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_hold, a_flush, a_valid, a_regw, a_load, a_stall, a_exv;
    logic [9:0] a_rs;
    logic [1:0] a_used;
    logic [4:0] a_rd;
    logic [3:0] a_sel;
    logic [15:0] a_cnt;

    logic       b_hold, b_flush, b_valid, b_regw, b_load, b_stall, b_exv;
    logic [9:0] b_rs;
    logic [1:0] b_used;
    logic [4:0] b_rd;
    logic [3:0] b_sel;
    logic [2:0] b_cnt;

    fwd_hazard_scoreboard u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (a_hold),
        .flush      (a_flush),
        .id_valid   (a_valid),
        .id_rs      (a_rs),
        .id_rs_used (a_used),
        .id_rd      (a_rd),
        .id_reg_w   (a_regw),
        .id_is_load (a_load),
        .stall      (a_stall),
        .ex_valid   (a_exv),
        .ex_fwd_sel (a_sel),
        .stall_cnt  (a_cnt)
    );

    fwd_hazard_scoreboard #(.DEPTH(4), .LOAD_READY(4), .CNT_W(3)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (b_hold),
        .flush      (b_flush),
        .id_valid   (b_valid),
        .id_rs      (b_rs),
        .id_rs_used (b_used),
        .id_rd      (b_rd),
        .id_reg_w   (b_regw),
        .id_is_load (b_load),
        .stall      (b_stall),
        .ex_valid   (b_exv),
        .ex_fwd_sel (b_sel),
        .stall_cnt  (b_cnt)
    );

    typedef struct packed {
        logic        v;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [1:0]  used;
        logic [4:0]  rd;
        logic        regw;
        logic        load;
        logic        flush;
        logic        hold;
        logic        e_stall;
        logic        e_exv;
        logic [1:0]  e_sel0;
        logic [1:0]  e_sel1;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct packed {
        logic        exv;
        logic [1:0]  sel0;
        logic [1:0]  sel1;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[29];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cur_row  = 0;

    function automatic vec_t mk(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                                input logic [1:0] used, input logic [4:0] rd, input logic regw,
                                input logic load, input logic flush, input logic hold,
                                input logic e_stall, input logic e_exv, input logic [1:0] e_sel0,
                                input logic [1:0] e_sel1, input logic [15:0] e_cnt);
        vec_t r;
        r = '{v, rs0, rs1, used, rd, regw, load, flush, hold, e_stall, e_exv, e_sel0, e_sel1, e_cnt};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, cur_row, act, exp);
        end
    endtask

    task automatic idle();
        a_hold = 0; a_flush = 0; a_valid = 0; a_rs = '0; a_used = '0; a_rd = '0; a_regw = 0; a_load = 0;
        b_hold = 0; b_flush = 0; b_valid = 0; b_rs = '0; b_used = '0; b_rd = '0; b_regw = 0; b_load = 0;
    endtask

    task automatic step(input vec_t t, input bit on_b);
        exp_t e;
        @(negedge clk);
        idle();
        if (!on_b) begin
            a_valid = t.v; a_rs = {t.rs1, t.rs0}; a_used = t.used; a_rd = t.rd;
            a_regw = t.regw; a_load = t.load; a_flush = t.flush; a_hold = t.hold;
        end else begin
            b_valid = t.v; b_rs = {t.rs1, t.rs0}; b_used = t.used; b_rd = t.rd;
            b_regw = t.regw; b_load = t.load; b_flush = t.flush; b_hold = t.hold;
        end
        #2;
        chk("stall", on_b ? b_stall : a_stall, t.e_stall);
        sbq.push_back('{t.e_exv, t.e_sel0, t.e_sel1, t.e_cnt});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("ex_valid", on_b ? b_exv : a_exv, e.exv);
        chk("sel0", on_b ? b_sel[1:0] : a_sel[1:0], e.sel0);
        chk("sel1", on_b ? b_sel[3:2] : a_sel[3:2], e.sel1);
        chk("stall_cnt", on_b ? {13'b0, b_cnt} : a_cnt, e.cnt);
    endtask

    initial begin
        logic [15:0] ec;
        //          v  rs0 rs1 used   rd regw ld fl ho | st exv s0 s1 cnt
        tbl[0]  = mk(1, 0,  0, 2'b00, 3, 1, 0, 0, 0,   0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 3,  0, 2'b01, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
        tbl[2]  = mk(1, 0,  0, 2'b00, 5, 1, 0, 0, 0,   0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 0,  0, 2'b00, 6, 1, 0, 0, 0,   0, 1, 0, 0, 0);
        tbl[4]  = mk(1, 9,  5, 2'b10, 0, 0, 0, 0, 0,   0, 1, 0, 2, 0);
        tbl[5]  = mk(1, 0,  0, 2'b00, 7, 1, 0, 0, 0,   0, 1, 0, 0, 0);
        tbl[6]  = mk(1, 0,  0, 2'b00, 7, 1, 0, 0, 0,   0, 1, 0, 0, 0);
        tbl[7]  = mk(1, 7,  7, 2'b11, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0);
        tbl[8]  = mk(1, 0,  0, 2'b00, 4, 1, 1, 0, 0,   0, 1, 0, 0, 0);
        tbl[9]  = mk(1, 4,  0, 2'b01, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1);
        tbl[10] = mk(1, 4,  0, 2'b01, 0, 0, 0, 0, 0,   0, 1, 2, 0, 1);
        tbl[11] = mk(1, 0,  0, 2'b00, 0, 1, 1, 0, 0,   0, 1, 0, 0, 1);
        tbl[12] = mk(1, 0,  0, 2'b11, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1);
        tbl[13] = mk(1, 0,  0, 2'b00, 8, 1, 1, 0, 0,   0, 1, 0, 0, 1);
        tbl[14] = mk(1, 8,  8, 2'b00, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1);
        tbl[15] = mk(1, 0,  0, 2'b00, 10, 1, 1, 0, 0,  0, 1, 0, 0, 1);
        tbl[16] = mk(1, 10, 0, 2'b01, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1);
        tbl[17] = mk(1, 10, 0, 2'b01, 0, 0, 0, 0, 0,   0, 1, 2, 0, 1);
        tbl[18] = mk(1, 0,  0, 2'b00, 11, 1, 1, 0, 0,  0, 1, 0, 0, 1);
        tbl[19] = mk(1, 11, 0, 2'b01, 0, 0, 0, 0, 1,   1, 1, 0, 0, 1);
        tbl[20] = mk(1, 11, 0, 2'b01, 0, 0, 0, 0, 1,   1, 1, 0, 0, 1);
        tbl[21] = mk(1, 11, 0, 2'b01, 0, 0, 0, 0, 1,   1, 1, 0, 0, 1);
        tbl[22] = mk(1, 11, 0, 2'b01, 0, 0, 0, 0, 0,   1, 0, 0, 0, 2);
        tbl[23] = mk(1, 11, 0, 2'b01, 0, 0, 0, 0, 0,   0, 1, 2, 0, 2);
        tbl[24] = mk(1, 0,  0, 2'b00, 12, 1, 0, 0, 1,  0, 1, 2, 0, 2);
        tbl[25] = mk(1, 0,  0, 2'b00, 12, 1, 0, 0, 0,  0, 1, 0, 0, 2);
        tbl[26] = mk(1, 0,  0, 2'b00, 13, 1, 1, 0, 0,  0, 1, 0, 0, 2);
        tbl[27] = mk(0, 13, 0, 2'b01, 0, 0, 0, 0, 0,   0, 0, 1, 0, 2);
        tbl[28] = mk(1, 0,  0, 2'b00, 14, 1, 1, 0, 0,  0, 1, 0, 0, 2);

        idle();
        rst_n = 1'b0;
        #12;
        cur_row = -1;
        chk("rst stall", a_stall, 0);
        chk("rst ex_valid", a_exv, 0);
        chk("rst sel", a_sel, 0);
        chk("rst stall_cnt", a_cnt, 0);
        chk("rst b stall_cnt", b_cnt, 0);
        chk("rst b ex_valid", b_exv, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 29; r++) begin
            cur_row = r;
            step(tbl[r], 1'b0);
        end

        // Asynchronous reset between edges while a load-use stall is live.
        cur_row = 100;
        @(negedge clk);
        idle();
        a_valid = 1; a_rs = {5'd0, 5'd14}; a_used = 2'b01;
        #2;
        chk("pre-reset stall", a_stall, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async stall", a_stall, 0);
        chk("async ex_valid", a_exv, 0);
        chk("async sel", a_sel, 0);
        chk("async stall_cnt", a_cnt, 0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // Deeper instance: two-cycle load-use stall and a 3-bit saturating counter.
        ec = 0;
        for (int n = 0; n < 10; n++) begin
            cur_row = 200 + n;
            step(mk(1, 0, 0, 2'b00, 4, 1, 1, 0, 0, 0, 1, 0, 0, ec), 1'b1);
            ec = (ec == 16'd7) ? ec : ec + 16'd1;
            step(mk(1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0, ec), 1'b1);
            ec = (ec == 16'd7) ? ec : ec + 16'd1;
            step(mk(1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0, ec), 1'b1);
            step(mk(1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 3, 0, ec), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
